ps2_rx_framed: RTL and testbench
================================

// Module: ps2_rx_framed
// PURPOSE
//  Parametrised PS/2 device-to-host receiver with full frame validation. Conditions the
//  PS/2 clock and data lines, shifts in start/data/parity/stop bits, and rejects bad frames.
//  Buffers good bytes in a first-word-fall-through (FWFT) FIFO with a valid/ready handshake.
//  Host inhibit (clock held low) is supported. Sits between the PS/2 pins and the
//  keyboard/mouse decoders.
// PARAMETERS
//  DATA_BITS       8       payload bits per frame, sent LSB first
//  DEBOUNCE_CYCLES 50      consecutive equal clk samples before a line change is accepted
//  TIMEOUT_CYCLES  100000  max clk cycles between strobes inside a frame
//  FIFO_DEPTH      4       received-byte buffer entries (>=2, power of 2)
//  CHECK_PARITY    1       1: odd parity enforced; 0: parity bit captured but ignored
// PORTS
//  clk            in     1                     system clock
//  reset          in     1                     reset, synchronous, active-high
//  ps2_clock      inout  1                     PS/2 clock; driven only as 0 (inhibit), else 'z'
//  ps2_data       inout  1                     PS/2 data; never driven (always 'z')
//  inhibit        in     1                     1: host pulls ps2_clock low, receiver held idle
//  rx_data        out    DATA_BITS             FIFO head byte
//  rx_valid       out    1                     FIFO non-empty
//  rx_ready       in     1                     consumer accepts head when rx_valid && rx_ready
//  rx_parity_err  out    1                     1-cycle pulse: frame dropped, parity wrong
//  rx_frame_err   out    1                     1-cycle pulse: frame dropped, bad stop bit or timeout
//  overflow       out    1                     sticky: good frame dropped, FIFO full
//  fifo_count     out    $clog2(FIFO_DEPTH+1)  entries held
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, FIFO empty, filters load 1 (bus idle), ps2_clock='z'.
//  Conditioning: both lines pass a 2-flop synchroniser. Clock then passes the debounce filter:
//   filtered value changes only after DEBOUNCE_CYCLES identical samples.
//  Strobe: 1-cycle pulse on filtered clock 1->0. Data = synchronised ps2_data in that cycle.
//  FSM states IDLE, RECV, CHECK:
//   IDLE:  strobe with data=0 (start bit) -> RECV, bit counter=0, timeout counter=0.
//          Strobe with data=1 -> stay IDLE, no error.
//   RECV:  each strobe shifts data in; after DATA_BITS+2 strobes (data, parity, stop) -> CHECK.
//          Timeout counter clears on each strobe. At TIMEOUT_CYCLES -> IDLE, partial frame
//          discarded, rx_frame_err pulses.
//   CHECK: one cycle, then always -> IDLE. Priority, highest first:
//          stop=0 -> rx_frame_err;
//          CHECK_PARITY && XOR(data,parity)=0 -> rx_parity_err;
//          else push data.
//  Latency: stop-bit strobe at cycle N, CHECK at N+1. With FIFO empty, rx_valid=1 and
//   rx_data valid at N+2.
//  FIFO: FWFT. Pop on rx_valid && rx_ready.
//   Push while full and no pop: byte dropped, overflow set (cleared only by reset).
//   Push while full with pop in the same cycle: both succeed, count unchanged.
//   Push+pop at any other count: count unchanged.
//  Inhibit=1: ps2_clock driven 0; FSM forced IDLE at next edge, in-progress frame discarded
//   silently (no error pulse); strobes ignored. FIFO contents and outputs retained.
//   Inhibit=0: ps2_clock released to 'z' the same cycle.
//  Reset mid-frame: frame discarded, FIFO flushed, overflow cleared.
// TESTING
//  1 Frame 0x1C, parity 0, stop 1, 30us bit period -> rx_data=0x1C, rx_valid=1 two clk after
//    the stop strobe; no error pulses.
//  2 Frame 0x1C with parity 1 -> rx_parity_err one pulse, rx_valid stays 0.
//    Repeat with CHECK_PARITY=0 -> 0x1C accepted.
//  3 Stop bit 0 -> rx_frame_err pulse, nothing pushed. Clock stopped after 4 data bits
//    -> rx_frame_err exactly TIMEOUT_CYCLES after the last strobe; next good frame received.
//  4 rx_ready=0, send 5 good frames with FIFO_DEPTH=4 -> fifo_count=4, overflow=1;
//    pops return frames 1-4 in order.
//  5 Assert inhibit mid-frame (after 3 bits) -> ps2_clock reads 0, no error pulse;
//    release, send 0xF0 -> 0xF0 received.
//  6 Clock glitches shorter than DEBOUNCE_CYCLES during a frame -> no extra strobes,
//    byte correct. Reset mid-frame -> all outputs 0, next frame correct.

Source files
------------

// File: rtl/ps2_rx_framed.sv
`timescale 1ns/1ps
// ps2_rx_framed
//   PS/2 device-to-host receiver with full frame validation.
//   The PS/2 clock and data lines are synchronised and the clock is debounced.
//   Each falling edge of the filtered clock produces a strobe that samples data.
//   Each frame is start(0), DATA_BITS payload bits sent LSB first, odd parity, and stop(1).
//   A frame with a bad stop bit, bad parity or an inter-bit timeout is dropped with an
//   error pulse. Good bytes go into a first-word-fall-through FIFO.
//   Asserting inhibit pulls the PS/2 clock low and holds the receiver idle.
//
// Ports
//   clk, reset     system clock; synchronous active-high reset
//   ps2_clock      PS/2 clock pin; driven 0 while inhibit, otherwise released ('z')
//   ps2_data       PS/2 data pin; only read, never driven
//   inhibit        host inhibit request
//   rx_data        FIFO head byte (0 when the FIFO is empty)
//   rx_valid       FIFO non-empty
//   rx_ready       consumer accepts the head when rx_valid && rx_ready
//   rx_parity_err  1-cycle pulse: frame dropped because parity was wrong
//   rx_frame_err   1-cycle pulse: frame dropped because of a bad stop bit or a timeout
//   overflow       sticky flag: a good frame was dropped because the FIFO was full
//   fifo_count     number of entries held in the FIFO
module ps2_rx_framed #(
    parameter int DATA_BITS       = 8,
    parameter int DEBOUNCE_CYCLES = 50,
    parameter int TIMEOUT_CYCLES  = 100000,
    parameter int FIFO_DEPTH      = 4,
    parameter int CHECK_PARITY    = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    inout  wire                               ps2_clock,
    inout  wire                               ps2_data,
    input  logic                              inhibit,
    output logic [DATA_BITS-1:0]              rx_data,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic                              rx_parity_err,
    output logic                              rx_frame_err,
    output logic                              overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int FRAME_W = DATA_BITS + 2;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BIT_W   = $clog2(FRAME_W + 1);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    // The error register adds one cycle, so the counter stops one short.
    // This places the pulse exactly TIMEOUT_CYCLES after the last strobe.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    // Open-drain clock: the host only ever pulls low, and only to inhibit.
    assign ps2_clock = inhibit ? 1'b0 : 1'bz;

    // Stage p0/p1: two-flop synchronisers, idle-high after reset
    logic clock_p0, clock_p1, data_p0, data_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            clock_p0 <= 1'b1;
            clock_p1 <= 1'b1;
            data_p0  <= 1'b1;
            data_p1  <= 1'b1;
        end else begin
            clock_p0 <= ps2_clock;
            clock_p1 <= clock_p0;
            data_p0  <= ps2_data;
            data_p1  <= data_p0;
        end
    end

    // Debounce: accept a new clock level after DEBOUNCE_CYCLES identical samples
    logic             clk_filt, clk_filt_q;
    logic [DEB_W-1:0] deb_cnt;
    logic             strobe;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_filt   <= 1'b1;
            clk_filt_q <= 1'b1;
            deb_cnt    <= '0;
        end else begin
            clk_filt_q <= clk_filt;
            if (clock_p1 == clk_filt) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                clk_filt <= clock_p1;
                deb_cnt  <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign strobe = clk_filt_q & ~clk_filt;

    // Frame FSM with inter-strobe timeout
    logic [1:0]         state;
    logic [BIT_W-1:0]   bit_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [FRAME_W-1:0] frame_sr;
    logic               stop_bit, parity_ok, push_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            tmo_cnt       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            if (inhibit) begin
                // A partial frame is dropped silently; the host caused it.
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (strobe && !data_p1) begin
                            state   <= RECV;
                            bit_cnt <= '0;
                            tmo_cnt <= '0;
                        end
                    end
                    RECV: begin
                        if (strobe) begin
                            tmo_cnt <= '0;
                            if (bit_cnt == BIT_LAST)
                                state <= CHECK;
                            else
                                bit_cnt <= bit_cnt + 1'b1;
                        end else if (tmo_cnt == TMO_LAST) begin
                            state        <= IDLE;
                            rx_frame_err <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    CHECK: begin
                        state <= IDLE;
                        if (!stop_bit)
                            rx_frame_err <= 1'b1;
                        else if (CHECK_PARITY != 0 && !parity_ok)
                            rx_parity_err <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Bits enter at the top, so after a full frame the layout is {stop, parity, payload}.
    always_ff @(posedge clk) begin
        if (state == RECV && strobe && !inhibit)
            frame_sr <= {data_p1, frame_sr[FRAME_W-1:1]};
    end

    assign stop_bit  = frame_sr[FRAME_W-1];
    assign parity_ok = ^frame_sr[FRAME_W-2:0];
    assign push_req  = (state == CHECK) && !inhibit && stop_bit &&
                       (parity_ok || CHECK_PARITY == 0);

    // FWFT FIFO
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic                 pop, push, full;

    assign rx_valid = (fifo_count != '0);
    assign full     = (fifo_count == CNT_FULL);
    assign pop      = rx_valid && rx_ready;
    // When the FIFO is full, a push succeeds only if a pop frees a slot in the same cycle.
    assign push     = push_req && (!full || pop);
    assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= frame_sr[DATA_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push_req && full && !pop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_rx_framed.sv
`timescale 1ns/1ps
// Directed bench for ps2_rx_framed.
// The bench acts as the PS/2 device on open-drain lines with pull-ups.
// The bit period is shortened to 2*HALF clk cycles. The debounce and timeout limits are
// also reduced to keep the run short.
// A second instance with CHECK_PARITY=0 and a constantly ready consumer shares the bus.
module tb_ps2_rx_framed;
    localparam int HALF = 20;
    localparam int DEB  = 4;
    localparam int TMO  = 200;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic inhibit = 1'b0;
    logic rx_ready = 1'b0;
    logic np_ready = 1'b1;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;

    wire ps2_clock, ps2_data;
    assign ps2_clock = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data  = dev_data_low ? 1'b0 : 1'bz;
    pullup (ps2_clock);
    pullup (ps2_data);

    logic [7:0] rx_data, np_data;
    logic       rx_valid, rx_parity_err, rx_frame_err, overflow;
    logic       np_valid, np_parity_err, np_frame_err, np_overflow;
    logic [2:0] fifo_count, np_count;

    ps2_rx_framed #(.DATA_BITS(8), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO),
                    .FIFO_DEPTH(4), .CHECK_PARITY(1)) dut (
        .clk(clk), .reset(reset), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
        .inhibit(inhibit), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
        .overflow(overflow), .fifo_count(fifo_count));

    ps2_rx_framed #(.DATA_BITS(8), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO),
                    .FIFO_DEPTH(4), .CHECK_PARITY(0)) dut_np (
        .clk(clk), .reset(reset), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
        .inhibit(inhibit), .rx_data(np_data), .rx_valid(np_valid), .rx_ready(np_ready),
        .rx_parity_err(np_parity_err), .rx_frame_err(np_frame_err),
        .overflow(np_overflow), .fifo_count(np_count));

    always #5 clk = ~clk;

    int pe_cnt = 0;
    int fe_cnt = 0;
    always @(posedge clk) begin
        if (rx_parity_err) pe_cnt <= pe_cnt + 1;
        if (rx_frame_err)  fe_cnt <= fe_cnt + 1;
    end

    int errors = 0;
    int checks = 0;
    int pe0, fe0;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Set data during the high phase, then pull the clock low; returns right after the fall.
    task automatic bit_fall(input logic b);
        dev_data_low = ~b;
        tick(HALF);
        dev_clk_low = 1'b1;
    endtask

    task automatic bit_rise();
        tick(HALF);
        dev_clk_low = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_fall(b);
        bit_rise();
    endtask

    // Each bit gets a 2-cycle low glitch in its high phase and a 2-cycle high glitch in its low phase.
    task automatic send_bit_glitch(input logic b);
        dev_data_low = ~b;
        tick(HALF/2);
        dev_clk_low = 1'b1; tick(2); dev_clk_low = 1'b0;
        tick(HALF/2 - 2);
        dev_clk_low = 1'b1;
        tick(HALF/2);
        dev_clk_low = 1'b0; tick(2); dev_clk_low = 1'b1;
        tick(HALF/2 - 2);
        dev_clk_low = 1'b0;
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        return ~(^b);
    endfunction

    task automatic send_head(input logic [7:0] b, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop);
        send_head(b, odd_par(b) ^ flip);
        send_bit(stop);
        dev_data_low = 1'b0;
        tick(HALF);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, {31'b0, rx_valid}, 32'd1);
        check({tag, "_data"}, {24'b0, rx_data}, {24'b0, exp});
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(5);
        check("rst_valid", {31'b0, rx_valid}, 32'd0);
        check("rst_data", {24'b0, rx_data}, 32'd0);
        check("rst_count", {29'b0, fifo_count}, 32'd0);
        check("rst_ovf", {31'b0, overflow}, 32'd0);
        check("rst_perr", {31'b0, rx_parity_err}, 32'd0);
        check("rst_ferr", {31'b0, rx_frame_err}, 32'd0);
        check("rst_ps2clk", {31'b0, ps2_clock}, 32'd1);
        reset = 1'b0;
        tick(10);

        // 1: good frame 0x1C and its latency from the stop-bit clock fall
        pe0 = pe_cnt; fe0 = fe_cnt;
        send_head(8'h1C, 1'b0);
        bit_fall(1'b1);
        tick(DEB + 3);
        check("t1_valid_early", {31'b0, rx_valid}, 32'd0);
        tick(1);
        check("t1_valid", {31'b0, rx_valid}, 32'd1);
        check("t1_data", {24'b0, rx_data}, 32'h1C);
        tick(HALF - DEB - 4);
        dev_clk_low = 1'b0;
        tick(HALF);
        check("t1_no_perr", 32'(pe_cnt - pe0), 32'd0);
        check("t1_no_ferr", 32'(fe_cnt - fe0), 32'd0);
        pop_check("t1_pop", 8'h1C);
        check("t1_empty", {31'b0, rx_valid}, 32'd0);

        // 2: bad parity dropped by checker, accepted by the CHECK_PARITY=0 instance
        pe0 = pe_cnt;
        send_head(8'h1C, 1'b1);
        bit_fall(1'b1);
        tick(DEB + 4);
        check("t2_np_valid", {31'b0, np_valid}, 32'd1);
        check("t2_np_data", {24'b0, np_data}, 32'h1C);
        tick(1);
        check("t2_np_popped", {31'b0, np_valid}, 32'd0);
        tick(HALF - DEB - 5);
        dev_clk_low = 1'b0;
        tick(HALF);
        check("t2_perr_pulses", 32'(pe_cnt - pe0), 32'd1);
        check("t2_valid", {31'b0, rx_valid}, 32'd0);

        // 3a: stop bit 0
        fe0 = fe_cnt;
        send_frame(8'h5A, 1'b0, 1'b0);
        check("t3_stop_ferr", 32'(fe_cnt - fe0), 32'd1);
        check("t3_stop_count", {29'b0, fifo_count}, 32'd0);

        // 3b: clock stops after four data bits
        fe0 = fe_cnt;
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        bit_fall(1'b1);
        tick(HALF);
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        tick(DEB + 1 + TMO - HALF);
        check("t3_tmo_early", {31'b0, rx_frame_err}, 32'd0);
        tick(1);
        check("t3_tmo_pulse", {31'b0, rx_frame_err}, 32'd1);
        tick(1);
        check("t3_tmo_end", {31'b0, rx_frame_err}, 32'd0);
        check("t3_tmo_count", 32'(fe_cnt - fe0), 32'd1);
        send_frame(8'h3B, 1'b0, 1'b1);
        pop_check("t3_after", 8'h3B);

        // 4: overflow with a stalled consumer
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        send_frame(8'h33, 1'b0, 1'b1);
        send_frame(8'h44, 1'b0, 1'b1);
        check("t4_count_full", {29'b0, fifo_count}, 32'd4);
        check("t4_no_ovf", {31'b0, overflow}, 32'd0);
        send_frame(8'h55, 1'b0, 1'b1);
        check("t4_count", {29'b0, fifo_count}, 32'd4);
        check("t4_ovf", {31'b0, overflow}, 32'd1);
        pop_check("t4_pop1", 8'h11);
        pop_check("t4_pop2", 8'h22);
        pop_check("t4_pop3", 8'h33);
        pop_check("t4_pop4", 8'h44);
        check("t4_drained", {31'b0, rx_valid}, 32'd0);

        // 5: inhibit after three bits
        pe0 = pe_cnt; fe0 = fe_cnt;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        dev_data_low = 1'b0;
        inhibit = 1'b1;
        tick(2);
        check("t5_ps2clk_low", {31'b0, ps2_clock}, 32'd0);
        tick(40);
        inhibit = 1'b0;
        tick(1);
        check("t5_ps2clk_rel", {31'b0, ps2_clock}, 32'd1);
        tick(40);
        check("t5_no_err", 32'(pe_cnt - pe0 + fe_cnt - fe0), 32'd0);
        check("t5_ovf_kept", {31'b0, overflow}, 32'd1);
        send_frame(8'hF0, 1'b0, 1'b1);
        pop_check("t5_f0", 8'hF0);

        // 6a: glitchy clock
        pe0 = pe_cnt; fe0 = fe_cnt;
        send_bit_glitch(1'b0);
        for (int i = 0; i < 8; i++) send_bit_glitch(1'(8'hA5 >> i));
        send_bit_glitch(odd_par(8'hA5));
        send_bit_glitch(1'b1);
        dev_data_low = 1'b0;
        tick(HALF);
        check("t6_glitch_err", 32'(pe_cnt - pe0 + fe_cnt - fe0), 32'd0);
        check("t6_glitch_count", {29'b0, fifo_count}, 32'd1);
        check("t6_glitch_data", {24'b0, rx_data}, 32'hA5);

        // 6b: reset in the middle of a frame
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        dev_data_low = 1'b0;
        reset = 1'b1;
        tick(3);
        check("t6_rst_valid", {31'b0, rx_valid}, 32'd0);
        check("t6_rst_data", {24'b0, rx_data}, 32'd0);
        check("t6_rst_count", {29'b0, fifo_count}, 32'd0);
        check("t6_rst_ovf", {31'b0, overflow}, 32'd0);
        reset = 1'b0;
        tick(40);
        send_frame(8'h77, 1'b0, 1'b1);
        pop_check("t6_after", 8'h77);
        check("t6_end_count", {29'b0, fifo_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
